// File: rtl/rx_sig_demodulate.sv
// 802.11a SIGNAL-symbol BPSK demapper: 52 subcarriers in, 48 hard bits out.
// Optional pilot sign check: define RX_SIG_PILOT_CHECK_EN.
module rx_sig_demodulate #(
  parameter int IQ_W    = 32,
  parameter int GAP_MAX = 64,
  parameter int N_SC    = 52
) (
  input  logic            clk_Modulation,
  input  logic            reset_n,
  input  logic            rx_sig_demod_in_valid,
  input  logic [IQ_W-1:0] rx_sig_demod_in_re,
  input  logic [IQ_W-1:0] rx_sig_demod_in_im,
  output logic            rx_sig_demod_valid,
  output logic            rx_sig_demod_bit,
  output logic            rx_sig_demod_last,
  output logic            rx_sig_demod_done,
  output logic            rx_sig_demod_abort,
`ifdef RX_SIG_PILOT_CHECK_EN
  output logic            rx_sig_demod_pilot_err,
`endif
  output logic            rx_sig_demod_ovf
);

  localparam int GW = $clog2(GAP_MAX);

  typedef enum logic [1:0] {
    IDLE,
    DEMOD,
    HOLD
  } state_t;

  state_t        state_q;
  logic [5:0]    sc_q;
  logic [GW-1:0] gap_q;
  logic          valid_q;
  logic          bit_q;
  logic          last_q;
  logic          abort_q;
  logic          ovf_q;

  logic accept;
  logic pilot;
  logic sc_last;
  logic gap_hit;
  logic sign;

  always_comb begin
    accept  = rx_sig_demod_in_valid
              && (state_q != HOLD);
    pilot   = (sc_q == 6'd5)  || (sc_q == 6'd19)
           || (sc_q == 6'd32) || (sc_q == 6'd46);
    sc_last = (sc_q == 6'(N_SC - 1));
    gap_hit = (state_q == DEMOD)
              && !rx_sig_demod_in_valid
              && (gap_q == GW'(GAP_MAX - 1));
    sign    = rx_sig_demod_in_re[IQ_W-1];
  end

  always_ff @(posedge clk_Modulation) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sc_q    <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
      last_q  <= 1'b0;
      abort_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= accept && !pilot;
      bit_q   <= accept && !pilot && !sign;
      last_q  <= accept && sc_last;
      abort_q <= gap_hit;
      unique case (state_q)
        IDLE: begin
          if (rx_sig_demod_in_valid) begin
            state_q <= DEMOD;
            sc_q    <= sc_q + 6'd1;
            gap_q   <= '0;
          end
        end
        DEMOD: begin
          if (rx_sig_demod_in_valid) begin
            gap_q <= '0;
            if (sc_last) begin
              state_q <= HOLD;
              sc_q    <= '0;
            end else begin
              sc_q <= sc_q + 6'd1;
            end
          end else if (gap_hit) begin
            state_q <= IDLE;
            sc_q    <= '0;
            gap_q   <= '0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        HOLD: begin
          // Samples here belong to nobody; flag and drop.
          if (rx_sig_demod_in_valid) ovf_q <= 1'b1;
          else                       state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RX_SIG_PILOT_CHECK_EN
  logic [2:0] pcnt_q;
  logic       perr_q;
  logic       pmis;

  // Expected pilot signs +,+,+,- : only sc 46 should be negative.
  always_comb begin
    pmis = pilot && (sign != (sc_q == 6'd46));
  end

  always_ff @(posedge clk_Modulation) begin
    if (!reset_n) begin
      pcnt_q <= '0;
      perr_q <= 1'b0;
    end else begin
      if (accept) begin
        if (sc_q == 6'd0) pcnt_q <= '0;
        else if (pmis)    pcnt_q <= pcnt_q + 3'd1;
      end
      if (accept && sc_last) perr_q <= (pcnt_q >= 3'd2);
      else if (gap_hit)      perr_q <= 1'b0;
    end
  end

  assign rx_sig_demod_pilot_err = perr_q;
`endif

  logic unused_ok;
  assign unused_ok = ^rx_sig_demod_in_im;

  assign rx_sig_demod_valid = valid_q;
  assign rx_sig_demod_bit   = bit_q;
  assign rx_sig_demod_last  = last_q;
  assign rx_sig_demod_done  = last_q;
  assign rx_sig_demod_abort = abort_q;
  assign rx_sig_demod_ovf   = ovf_q;

endmodule

// File: tb/tb_rx_sig_demodulate.sv
// Randomized bench for rx_sig_demodulate with a symbol-level model.
// Define RX_SIG_PILOT_CHECK_EN to also check pilot_err.
module tb_rx_sig_demodulate;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv = 1'b0;
  logic [31:0] re = '0;
  logic [31:0] im = '0;
  logic        ov, ob, ol, od, oa, oovf;
`ifdef RX_SIG_PILOT_CHECK_EN
  logic        ope;
`endif

  always #5 clk = ~clk;

  rx_sig_demodulate #(
    .IQ_W(32), .GAP_MAX(64), .N_SC(52)
  ) dut (
    .clk_Modulation(clk),
    .reset_n(rst_n),
    .rx_sig_demod_in_valid(iv),
    .rx_sig_demod_in_re(re),
    .rx_sig_demod_in_im(im),
    .rx_sig_demod_valid(ov),
    .rx_sig_demod_bit(ob),
    .rx_sig_demod_last(ol),
    .rx_sig_demod_done(od),
    .rx_sig_demod_abort(oa),
`ifdef RX_SIG_PILOT_CHECK_EN
    .rx_sig_demod_pilot_err(ope),
`endif
    .rx_sig_demod_ovf(oovf)
  );

  int   checks = 0;
  int   errors = 0;
  logic exp_ovf = 1'b0;
  logic exp_pe = 1'b0;
  int   pmode = 0;
  int   nval, nones, ndone;

  function automatic logic is_pilot(int k);
    return (k == 5) || (k == 19) || (k == 32) || (k == 46);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive, clock, then compare against the model's expectation.
  task automatic step(input logic v, input logic [31:0] r,
                      input logic ev, input logic eb,
                      input logic el, input logic ea);
    iv = v;
    re = r;
    im = $urandom;
    @(posedge clk);
    #1;
    chk("valid", ov, ev);
    if (ev || !rst_n) chk("bit", ob, eb);
    chk("last", ol, el);
    chk("done", od, el);
    chk("abort", oa, ea);
    chk("ovf", oovf, exp_ovf);
`ifdef RX_SIG_PILOT_CHECK_EN
    chk("pilot_err", ope, exp_pe);
`endif
    if (ov) nval++;
    if (ov && ob) nones++;
    if (od) ndone++;
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // mode 0 random data, 1 all +1.0, 2 alternating +/-1 with one zero.
  task automatic send_sym(int nsamp, int mode, int maxgap, int zidx);
    int d = 0;
    int mm = 0;
    logic s;
    logic [31:0] r;
    nval = 0;
    nones = 0;
    ndone = 0;
    for (int k = 0; k < nsamp; k++) begin
      if (k > 0 && k < 52 && maxgap > 0)
        idle($urandom_range(0, maxgap));
      if (k < 52 && is_pilot(k)) begin
        if (pmode == 0)      s = (k == 46);
        else if (pmode == 1) s = (k != 46);
        else                 s = 1'($urandom_range(0, 1));
        r = {s, 31'($urandom)};
        if (s != (k == 46)) mm++;
      end else if (mode == 1) begin
        r = 32'h4000_0000;
      end else if (mode == 2) begin
        if (d == zidx)      r = 32'h0;
        else if (d % 2 == 0) r = 32'h4000_0000;
        else                 r = 32'hC000_0000;
      end else begin
        r = $urandom;
      end
      if (k < 52) begin
        if (k == 51) exp_pe = (mm >= 2);
        step(1'b1, r, !is_pilot(k), ~r[31], k == 51, 1'b0);
        if (!is_pilot(k)) d++;
      end else begin
        exp_ovf = 1'b1;
        step(1'b1, r, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    pmode = 0;
    send_sym(52, 1, 0, -1);
    chk("t1_nbits", nval, 48);
    chk("t1_ones", nones, 48);
    chk("t1_done", ndone, 1);
    idle(1);

    send_sym(52, 2, 0, 7);
    chk("t2_nbits", nval, 48);
    chk("t2_ones", nones, 25);
    idle(2);

    pmode = 2;
    for (int i = 0; i < 4; i++) begin
      send_sym(52, 0, 63, -1);
      chk("t3_nbits", nval, 48);
      chk("t3_done", ndone, 1);
      idle($urandom_range(1, 3));
    end

    send_sym(30, 0, 5, -1);
    chk("t4_partial", nval, 28);
    idle(63);
    exp_pe = 1'b0;
    step(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b1);
    send_sym(52, 0, 0, -1);
    chk("t4_nbits", nval, 48);
    idle(1);

    send_sym(56, 0, 0, -1);
    chk("t5_nbits", nval, 48);
    chk("t5_done", ndone, 1);
    chk("t5_ovf", oovf, 1);
    idle(1);
    send_sym(52, 0, 10, -1);
    chk("t5_next", nval, 48);
    idle(1);

    send_sym(20, 0, 3, -1);
    rst_n = 1'b0;
    exp_ovf = 1'b0;
    exp_pe = 1'b0;
    ndone = 0;
    step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(3);
    chk("rst_nodone", ndone, 0);
    send_sym(52, 0, 2, -1);
    chk("rst_next", nval, 48);
    idle(1);

    pmode = 0;
    send_sym(52, 0, 0, -1);
`ifdef RX_SIG_PILOT_CHECK_EN
    chk("t6_pe_good", ope, 0);
`endif
    idle(1);
    pmode = 1;
    send_sym(52, 0, 0, -1);
`ifdef RX_SIG_PILOT_CHECK_EN
    chk("t6_pe_bad", ope, 1);
`endif
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
